calc_seq: RTL
=============

# calc_seq

Keypad-driven sequencer for the 8-bit seven-segment calculator datapath. Accepts single-cycle key events, builds decimal operands A and B, selects the operation, drives the combinational ALU for a fixed settle window, and latches result and remainder for the display stage. Sits between the debounced key decoder and the calculator top; the calculator's operand and op inputs are owned by this block.

## Interface
- W, 8: operand/result width.
- EXEC_CYCLES, 1: cycles the ALU inputs are held stable before the result is latched (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  5  0–9 digit, 10–14 op select (op = code−10), 15 EQ, 16 CLR, 17 BKSP; others invalid.
- alu_a, alu_b  out  W  registered operands to datapath.
- alu_op  out  3  0 add, 1 sub, 2 mul, 3 div, 4 mod.
- alu_out, alu_rm  in  W  datapath result and remainder.
- disp_val, disp_rm  out  W  value to display, remainder (0 unless op 3).
- disp_mode  out  2  0 entering A, 1 entering B, 2 result, 3 error.
- res_valid  out  1  one-cycle pulse when result latched.
- busy  out  1  high in EXEC.
- key_rej  out  1  one-cycle pulse, cycle after a rejected key.

## Operation
- States: ENT_A, ENT_B, EXEC, SHOW, ERR. Reset: ENT_A; all outputs 0.
- Digit in ENT_A/ENT_B: acc = acc*10 + d, computed at W+4 bits; if >2^W−1, digit dropped, key_rej. disp_val = current acc.
- BKSP: acc = acc/10 (integer). CLR from any state except EXEC: all registers 0, → ENT_A.
- Op key in ENT_A: store op, → ENT_B (B acc = 0). Op key in ENT_B: replaces op, B unchanged.
- EQ in ENT_B: if op ∈ {3,4} and B = 0 → ERR (disp_mode 3, disp_val 0); else → EXEC. EQ in ENT_A: key_rej.
- EXEC: alu_a/alu_b/alu_op held; counter runs EXEC_CYCLES; on last cycle alu_out/alu_rm captured into disp_val/disp_rm, res_valid, → SHOW. Result width rules belong to datapath (mul/sub wrap mod 2^W); no check here.
- All keys during EXEC: ignored, key_rej.
- SHOW: digit → ENT_A with acc = digit. ERR: only CLR accepted; others key_rej.
- Op code 15–17 decode exclusive; codes 18–31 → key_rej in every state.

## Timing
- Key sampled in strobe cycle t; state/accumulator updated at t+1 edge.
- EQ at t: busy high t+1 … t+EXEC_CYCLES; res_valid and disp_mode=2 at t+1+EXEC_CYCLES.
- alu_* registered, change only on ENT_x→EXEC transition and CLR.
- rst_n assert mid-EXEC: immediate async clear, no res_valid.
- key_valid held >1 cycle counts as repeated keys (debouncer's responsibility).

## Configuration
- CALC_CHAIN_EN defined: op key in SHOW loads A = disp_val, stores op, → ENT_B (result chaining).
- Undefined: op key in SHOW → key_rej, state unchanged.

## Structure
- calc_pkg: key code constants, op codes, state encoding, disp_mode encoding.
- Sub-module calc_dec_acc: decimal accumulator (digit insert with overflow flag, backspace, clear), instanced once, shared between A and B entry via a select.

## Test plan
- Keys 1,0,+(10),2,EQ → alu_a=10, alu_b=2, alu_op=0; res_valid 2 cycles after EQ; disp_val=12.
- Keys 2,5,5,9 → 9 rejected (key_rej pulse), disp_val=255; BKSP → 25.
- Keys 7, div(13), 0, EQ → disp_mode=3; digit 5 → key_rej; CLR → disp_mode 0, disp_val 0.
- 1,1,1, mul(12), 2, EQ, then add(10) during busy → key_rej, result = datapath 222 latched unchanged.
- After 10+2=12 result, sub(11), 2, EQ → with CALC_CHAIN_EN disp_val=10; without, sub rejected.
- EXEC_CYCLES=3, rst_n low on 2nd busy cycle → all outputs 0 immediately, no res_valid, ENT_A after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator sequencer: key codes, ALU op codes,
// sequencer state, display mode and key classification.
package calc_pkg;

  localparam logic [4:0] KEY_DIG_HI = 5'd9;
  localparam logic [4:0] KEY_OP_LO  = 5'd10;
  localparam logic [4:0] KEY_OP_HI  = 5'd14;
  localparam logic [4:0] KEY_EQ     = 5'd15;
  localparam logic [4:0] KEY_CLR    = 5'd16;
  localparam logic [4:0] KEY_BKSP   = 5'd17;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [2:0] {ST_ENT_A, ST_ENT_B, ST_EXEC, ST_SHOW, ST_ERR} state_e;
  typedef enum logic [1:0] {DM_ENT_A = 2'd0, DM_ENT_B = 2'd1, DM_RESULT = 2'd2, DM_ERROR = 2'd3} disp_mode_e;
  typedef enum logic [1:0] {ACC_HOLD, ACC_DIGIT, ACC_BKSP, ACC_CLR} acc_cmd_e;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OP, K_EQ, K_CLR, K_BKSP, K_BAD} key_cls_e;

  function automatic key_cls_e classify(input logic vld, input logic [4:0] code);
    key_cls_e k;
    if (!vld)                   k = K_NONE;
    else if (code <= KEY_DIG_HI) k = K_DIGIT;
    else if (code <= KEY_OP_HI)  k = K_OP;
    else if (code == KEY_EQ)     k = K_EQ;
    else if (code == KEY_CLR)    k = K_CLR;
    else if (code == KEY_BKSP)   k = K_BKSP;
    else                         k = K_BAD;
    return k;
  endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// Combinational decimal accumulator step: digit insert (acc*10+d with overflow
// flag), backspace (acc/10) and clear. The caller selects which operand feeds it.
module calc_dec_acc
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  acc_cmd_e       cmd,
  input  logic [W-1:0]   acc_i,
  input  logic [3:0]     digit_i,
  output logic [W-1:0]   acc_o,
  output logic           ovf_o
);

  logic [W+3:0] ext;

  always_comb begin
    ext   = ({4'd0, acc_i} * (W+4)'(10)) + {{W{1'b0}}, digit_i};
    acc_o = acc_i;
    ovf_o = 1'b0;
    case (cmd)
      // On overflow the digit is dropped and the operand keeps its old value.
      ACC_DIGIT: if (|ext[W+3:W]) ovf_o = 1'b1;
                 else             acc_o = ext[W-1:0];
      ACC_BKSP:  acc_o = acc_i / W'(10);
      ACC_CLR:   acc_o = '0;
      default:   ;
    endcase
  end

endmodule

// File: rtl/calc_seq.sv
// Keypad sequencer for the calculator datapath: operand entry, op select, timed
// ALU execution and result latch. CALC_CHAIN_EN enables op-key result chaining.
module calc_seq
  import calc_pkg::*;
#(
  parameter int W           = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] alu_rm,
  output logic [W-1:0] disp_val,
  output logic [W-1:0] disp_rm,
  output logic [1:0]   disp_mode,
  output logic         res_valid,
  output logic         busy,
  output logic         key_rej
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  disp_mode_e disp_mode_q, disp_mode_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [W-1:0] disp_val_q, disp_val_d, disp_rm_q, disp_rm_d;
  logic [2:0]   op_q, op_d, alu_op_q, alu_op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic res_valid_q, res_valid_d, busy_q, busy_d, key_rej_q, key_rej_d;

  key_cls_e     kc;
  acc_cmd_e     acc_cmd;
  logic         acc_sel_b, acc_ovf, clear_all;
  logic [W-1:0] acc_cur, acc_nxt;
  logic [4:0]   op_full;

  always_comb begin
    kc        = classify(key_valid, key_code);
    op_full   = key_code - KEY_OP_LO;
    acc_sel_b = (state_q == ST_ENT_B);
    acc_cur   = acc_sel_b ? b_q : a_q;
    acc_cmd   = ACC_HOLD;
    if (state_q == ST_ENT_A || state_q == ST_ENT_B) begin
      if (kc == K_DIGIT)     acc_cmd = ACC_DIGIT;
      else if (kc == K_BKSP) acc_cmd = ACC_BKSP;
    end
  end

  calc_dec_acc #(.W(W)) u_acc (
    .cmd     (acc_cmd),
    .acc_i   (acc_cur),
    .digit_i (key_code[3:0]),
    .acc_o   (acc_nxt),
    .ovf_o   (acc_ovf)
  );

  always_comb begin
    state_d     = state_q;
    disp_mode_d = disp_mode_q;
    a_d = a_q;  b_d = b_q;  op_d = op_q;
    alu_a_d = alu_a_q;  alu_b_d = alu_b_q;  alu_op_d = alu_op_q;
    disp_val_d = disp_val_q;  disp_rm_d = disp_rm_q;
    cnt_d = cnt_q;  busy_d = busy_q;
    res_valid_d = 1'b0;
    key_rej_d   = 1'b0;
    clear_all   = 1'b0;
    case (state_q)
      ST_ENT_A, ST_ENT_B: begin
        case (kc)
          K_DIGIT, K_BKSP: begin
            if (acc_ovf) key_rej_d = 1'b1;
            else begin
              if (acc_sel_b) b_d = acc_nxt;
              else           a_d = acc_nxt;
              disp_val_d = acc_nxt;
            end
          end
          K_OP: begin
            op_d = op_full[2:0];
            if (state_q == ST_ENT_A) begin
              b_d = '0;  disp_val_d = '0;
              state_d = ST_ENT_B;  disp_mode_d = DM_ENT_B;
            end
          end
          K_EQ: begin
            if (state_q == ST_ENT_A) key_rej_d = 1'b1;
            else if ((op_q == OP_DIV || op_q == OP_MOD) && b_q == '0) begin
              state_d = ST_ERR;  disp_mode_d = DM_ERROR;
              disp_val_d = '0;  disp_rm_d = '0;
            end else begin
              state_d = ST_EXEC;  busy_d = 1'b1;  cnt_d = '0;
              alu_a_d = a_q;  alu_b_d = b_q;  alu_op_d = op_q;
            end
          end
          K_CLR:   clear_all = 1'b1;
          K_BAD:   key_rej_d = 1'b1;
          default: ;
        endcase
      end
      ST_EXEC: begin
        if (kc != K_NONE) key_rej_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          disp_val_d  = alu_out;
          disp_rm_d   = (alu_op_q == OP_DIV) ? alu_rm : '0;
          res_valid_d = 1'b1;  busy_d = 1'b0;
          state_d = ST_SHOW;  disp_mode_d = DM_RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        case (kc)
          K_DIGIT: begin
            a_d = W'(key_code[3:0]);  b_d = '0;
            disp_val_d = W'(key_code[3:0]);  disp_rm_d = '0;
            state_d = ST_ENT_A;  disp_mode_d = DM_ENT_A;
          end
          K_OP: begin
`ifdef CALC_CHAIN_EN
            a_d = disp_val_q;  b_d = '0;  op_d = op_full[2:0];
            disp_val_d = '0;  disp_rm_d = '0;
            state_d = ST_ENT_B;  disp_mode_d = DM_ENT_B;
`else
            key_rej_d = 1'b1;
`endif
          end
          K_CLR:   clear_all = 1'b1;
          K_NONE:  ;
          default: key_rej_d = 1'b1;
        endcase
      end
      default: begin
        if (kc == K_CLR)       clear_all = 1'b1;
        else if (kc != K_NONE) key_rej_d = 1'b1;
      end
    endcase
    if (clear_all) begin
      state_d = ST_ENT_A;  disp_mode_d = DM_ENT_A;
      a_d = '0;  b_d = '0;  op_d = '0;
      alu_a_d = '0;  alu_b_d = '0;  alu_op_d = '0;
      disp_val_d = '0;  disp_rm_d = '0;
      cnt_d = '0;  busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENT_A;  disp_mode_q <= DM_ENT_A;
      a_q <= '0;  b_q <= '0;  op_q <= '0;
      alu_a_q <= '0;  alu_b_q <= '0;  alu_op_q <= '0;
      disp_val_q <= '0;  disp_rm_q <= '0;
      cnt_q <= '0;  busy_q <= 1'b0;  res_valid_q <= 1'b0;  key_rej_q <= 1'b0;
    end else begin
      state_q <= state_d;  disp_mode_q <= disp_mode_d;
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;
      alu_a_q <= alu_a_d;  alu_b_q <= alu_b_d;  alu_op_q <= alu_op_d;
      disp_val_q <= disp_val_d;  disp_rm_q <= disp_rm_d;
      cnt_q <= cnt_d;  busy_q <= busy_d;  res_valid_q <= res_valid_d;  key_rej_q <= key_rej_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign disp_val  = disp_val_q;
  assign disp_rm   = disp_rm_q;
  assign disp_mode = disp_mode_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign key_rej   = key_rej_q;

endmodule
